// File: rtl/csr_file_if.sv
// CSR file port bundle: read port, commit port, retire/trap strobes, fetch targets.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a single-cycle strobe or level.
// master: execute/trap side, drives addresses, write data and strobes.
// slave : csr_file, returns read data, illegal flags and fetch targets.
interface csr_file_if;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_illegal;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_illegal;
  logic        instret_inc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, instret_inc,
    output trap_valid, trap_pc, trap_cause,
    input  rd_data, rd_illegal, wr_illegal, mtvec_out, mepc_out
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, instret_inc,
    input  trap_valid, trap_pc, trap_cause,
    output rd_data, rd_illegal, wr_illegal, mtvec_out, mepc_out
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: mtvec/mscratch/mepc/mcause, 64-bit mcycle/minstret, trap capture.
// Latency: reads and illegal flags are combinational; writes/traps/increments visible next cycle.
// Backpressure: none; a commit or trap is always accepted in the cycle it is presented.
// Ports: clk, rst_n (async active-low), bus (csr_file_if.slave).
// Parameter MTVEC_RESET: reset value of mtvec, bits [1:0] forced to zero.
// Macro SAIL_CSR_COUNTERS_EN: builds the cycle/instret counters; when undefined the
// counter addresses stay mapped, read as zero and silently drop writes.
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  csr_file_if.slave  bus
);

  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;
  logic        wr_ok;
  logic        unused_bits;

  // Only the M-mode RW set is writable; the 0xCxx user aliases are read-only.
  always_comb begin
    bus.wr_illegal = 1'b0;
    if (bus.wr_en) begin
      case (bus.wr_addr)
        12'h305, 12'h340, 12'h341, 12'h342,
        12'hB00, 12'hB80, 12'hB02, 12'hB82: bus.wr_illegal = 1'b0;
        default:                             bus.wr_illegal = 1'b1;
      endcase
    end
  end

  assign wr_ok = bus.wr_en & ~bus.wr_illegal;

  always_comb begin
    bus.rd_data    = 32'h0;
    bus.rd_illegal = 1'b0;
    case (bus.rd_addr)
      12'h305:          bus.rd_data = mtvec_q;
      12'h340:          bus.rd_data = mscratch_q;
      12'h341:          bus.rd_data = mepc_q;
      12'h342:          bus.rd_data = mcause_q;
      12'hB00, 12'hC00: bus.rd_data = cyc_lo;
      12'hB80, 12'hC80: bus.rd_data = cyc_hi;
      12'hB02, 12'hC02: bus.rd_data = ins_lo;
      12'hB82, 12'hC82: bus.rd_data = ins_hi;
      default:          bus.rd_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
    end else begin
      if (wr_ok && bus.wr_addr == 12'h305) mtvec_q    <= {bus.wr_data[31:2], 2'b00};
      if (wr_ok && bus.wr_addr == 12'h340) mscratch_q <= bus.wr_data;
      // Trap capture overrides a same-cycle software write to mepc/mcause.
      if (bus.trap_valid) begin
        mepc_q   <= {bus.trap_pc[31:2], 2'b00};
        mcause_q <= bus.trap_cause;
      end else begin
        if (wr_ok && bus.wr_addr == 12'h341) mepc_q   <= {bus.wr_data[31:2], 2'b00};
        if (wr_ok && bus.wr_addr == 12'h342) mcause_q <= bus.wr_data;
      end
    end
  end

  assign bus.mtvec_out = mtvec_q;
  assign bus.mepc_out  = mepc_q;

`ifdef SAIL_CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;

  // A write to either half freezes the whole counter for that cycle: the written
  // half takes the new value, the other half neither increments nor takes a carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      if (wr_ok && bus.wr_addr == 12'hB00)      mcycle_q[31:0]  <= bus.wr_data;
      else if (wr_ok && bus.wr_addr == 12'hB80) mcycle_q[63:32] <= bus.wr_data;
      else                                      mcycle_q        <= mcycle_q + 64'd1;

      if (wr_ok && bus.wr_addr == 12'hB02)      minstret_q[31:0]  <= bus.wr_data;
      else if (wr_ok && bus.wr_addr == 12'hB82) minstret_q[63:32] <= bus.wr_data;
      else if (bus.instret_inc)                 minstret_q        <= minstret_q + 64'd1;
    end
  end

  assign cyc_lo = mcycle_q[31:0];
  assign cyc_hi = mcycle_q[63:32];
  assign ins_lo = minstret_q[31:0];
  assign ins_hi = minstret_q[63:32];
  assign unused_bits = ^bus.trap_pc[1:0];
`else
  assign cyc_lo = 32'h0;
  assign cyc_hi = 32'h0;
  assign ins_lo = 32'h0;
  assign ins_hi = 32'h0;
  assign unused_bits = ^{bus.trap_pc[1:0], bus.instret_inc};
`endif

endmodule
